// File: rtl/instr_mem_pipe.sv
// Loadable instruction store for the fetch stage: valid/ready fetch port with an
// RD_LAT-deep response pipeline, a run-time load port and a per-word loaded bitmap.
module instr_mem_pipe #(
   parameter int                DATA_W = 32,
   parameter int                DEPTH  = 64,
   parameter int                ADDR_W = 32,
   parameter int                RD_LAT = 1,
   parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              flush
);

   localparam int IDX_W = $clog2(DEPTH);

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("instr_mem_pipe: RD_LAT must be in 1..4");
   end
   if (DEPTH < 2 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
      $error("instr_mem_pipe: DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
      logic [1:0]        err;
      logic [DATA_W-1:0] data;
   } rsp_t;

   localparam rsp_t RST_PAY = '{err: 2'b00, data: FILL};

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  wvld_q, wvld_d;
   logic [RD_LAT:1]   vld_pipe_q;
   rsp_t              pay_q [RD_LAT:1];

   logic              stall, accept;
   logic              req_oor, ld_oor, ld_we;
   logic [IDX_W-1:0]  req_idx, ld_idx;
   rsp_t              s0_pay;
   logic              unused_ld;

   assign unused_ld = ^ld_addr[1:0];

   // Out of range means any word-index bit above the array index is set.
   assign req_oor = |(req_addr[ADDR_W-1:2] >> IDX_W);
   assign ld_oor  = |(ld_addr[ADDR_W-1:2] >> IDX_W);
   assign req_idx = req_addr[IDX_W+1:2];
   assign ld_idx  = ld_addr[IDX_W+1:2];
   assign ld_we   = ld_en & ~ld_oor;

   assign stall     = rsp_valid & ~rsp_ready;
   assign req_ready = ~stall & ~flush & rst;
   assign accept    = req_valid & req_ready;

   always_comb begin
      s0_pay.err  = {req_oor, |req_addr[1:0]};
      s0_pay.data = FILL;
      if (s0_pay.err == 2'b00 && wvld_q[req_idx]) begin
         s0_pay.data = mem_q[req_idx];
      end
   end

   always_comb begin
      wvld_d = wvld_q;
      if (ld_we) begin
         wvld_d[ld_idx] = 1'b1;
      end
   end

   // The read above sees the pre-edge array, so a same-edge load is read-first.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem_q[ld_idx] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wvld_q <= '0;
      end else begin
         wvld_q <= wvld_d;
      end
   end

   // Whole pipe freezes on stall; flush drops valids only, payloads are don't-care.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe_q <= '0;
         for (int s = 1; s <= RD_LAT; s++) begin
            pay_q[s] <= RST_PAY;
         end
      end else if (flush) begin
         vld_pipe_q <= '0;
      end else if (!stall) begin
         vld_pipe_q[1] <= accept;
         pay_q[1]      <= s0_pay;
         for (int s = 2; s <= RD_LAT; s++) begin
            vld_pipe_q[s] <= vld_pipe_q[s-1];
            pay_q[s]      <= pay_q[s-1];
         end
      end
   end

   assign rsp_valid = vld_pipe_q[RD_LAT];
   assign rsp_data  = pay_q[RD_LAT].data;
   assign rsp_err   = pay_q[RD_LAT].err;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: RD_LAT=1 and RD_LAT=3 instances share one stimulus stream;
// a queue-of-fetches model is compared every cycle, plus hand-computed literal checks.
module tb_instr_mem_pipe;

   localparam int          DEPTH = 64;
   localparam logic [31:0] FILL  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, rsp_ready = 1'b1, ld_en = 1'b0, flush = 1'b0;
   logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;

   logic        rdy1, vld1, rdy3, vld3;
   logic [31:0] dat1, dat3;
   logic [1:0]  err1, err3;

   int n_chk = 0;
   int n_fail = 0;

   // model state: per instance k (0 -> latency 1, 1 -> latency 3) a list of fetches in flight
   int          m_cnt [2];
   int          m_age [2][8];
   logic [31:0] m_dat [2][8];
   logic [1:0]  m_err [2][8];
   logic [31:0] mem_m [DEPTH];
   logic        vld_m [DEPTH];

   always #5 clk = ~clk;

   instr_mem_pipe #(.RD_LAT(1)) u1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_addr(req_addr),
      .rsp_valid(vld1), .rsp_ready(rsp_ready), .rsp_data(dat1), .rsp_err(err1),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .flush(flush));

   instr_mem_pipe #(.RD_LAT(3)) u3 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_addr(req_addr),
      .rsp_valid(vld3), .rsp_ready(rsp_ready), .rsp_data(dat3), .rsp_err(err3),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .flush(flush));

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: a fetch enters with age 1 on its accepting edge, ages on every unstalled edge,
   // is visible at age == latency and leaves on the next unstalled edge.
   initial begin : model
      logic        vis, stall, acc, exp_rdy;
      logic [1:0]  e;
      logic [31:0] d;
      int          idx;
      logic        o_vld [2], o_rdy [2];
      logic [31:0] o_dat [2];
      logic [1:0]  o_err [2];
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
      forever begin
         @(posedge clk);
         idx = int'(req_addr >> 2);
         e   = {idx >= DEPTH, req_addr[1:0] != 2'b00};
         d   = FILL;
         if (e == 2'b00) begin
            if (vld_m[idx]) d = mem_m[idx];
         end
         for (int k = 0; k < 2; k++) begin
            if (!rst) begin
               m_cnt[k] = 0;
            end else begin
               vis   = m_cnt[k] > 0 && m_age[k][0] == lat(k);
               stall = vis && !rsp_ready;
               acc   = req_valid && !stall && !flush;
               if (flush) begin
                  m_cnt[k] = 0;
               end else if (!stall) begin
                  if (vis) begin
                     for (int i = 1; i < m_cnt[k]; i++) begin
                        m_age[k][i-1] = m_age[k][i];
                        m_dat[k][i-1] = m_dat[k][i];
                        m_err[k][i-1] = m_err[k][i];
                     end
                     m_cnt[k]--;
                  end
                  for (int i = 0; i < m_cnt[k]; i++) m_age[k][i]++;
                  if (acc) begin
                     m_age[k][m_cnt[k]] = 1;
                     m_dat[k][m_cnt[k]] = d;
                     m_err[k][m_cnt[k]] = e;
                     m_cnt[k]++;
                  end
               end
            end
         end
         if (!rst) begin
            for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
         end else if (ld_en && (ld_addr >> 2) < DEPTH) begin
            mem_m[ld_addr[7:2]] = ld_data;
            vld_m[ld_addr[7:2]] = 1'b1;
         end

         @(negedge clk);
         if (!rst) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            for (int i = 0; i < DEPTH; i++) vld_m[i] = 1'b0;
         end
         o_vld[0] = vld1; o_rdy[0] = rdy1; o_dat[0] = dat1; o_err[0] = err1;
         o_vld[1] = vld3; o_rdy[1] = rdy3; o_dat[1] = dat3; o_err[1] = err3;
         for (int k = 0; k < 2; k++) begin
            vis     = rst && m_cnt[k] > 0 && m_age[k][0] == lat(k);
            exp_rdy = rst && !flush && !(vis && !rsp_ready);
            chk($sformatf("model rsp_valid L%0d t=%0t", lat(k), $time), 32'(o_vld[k]), 32'(vis));
            chk($sformatf("model req_ready L%0d t=%0t", lat(k), $time), 32'(o_rdy[k]), 32'(exp_rdy));
            if (vis) begin
               chk($sformatf("model rsp_data L%0d t=%0t", lat(k), $time), o_dat[k], m_dat[k][0]);
               chk($sformatf("model rsp_err L%0d t=%0t", lat(k), $time), 32'(o_err[k]), 32'(m_err[k][0]));
            end
            if (!rst) begin
               chk($sformatf("reset rsp_data L%0d", lat(k)), o_dat[k], FILL);
               chk($sformatf("reset rsp_err L%0d", lat(k)), 32'(o_err[k]), 32'd0);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: run exceeded time limit, expected $finish before 200000");
      $fatal(1);
   end

   initial begin : stim
      tick(); tick();
      chk("reset vld1", 32'(vld1), 32'd0);
      chk("reset vld3", 32'(vld3), 32'd0);
      chk("reset dat3", dat3, FILL);
      chk("reset rdy3", 32'(rdy3), 32'd0);
      rst = 1'b1;
      tick();

      // first fetch of an unloaded word, latency 1
      req_valid = 1'b1; req_addr = 32'h0;
      tick();
      req_valid = 1'b0;
      chk("first vld1", 32'(vld1), 32'd1);
      chk("first dat1", dat1, 32'h0000_0000);
      chk("first err1", 32'(err1), 32'd0);
      chk("first vld3 early", 32'(vld3), 32'd0);
      tick(); tick(); tick();

      // loads, then back-to-back fetches through the 3-stage instance
      ld_en = 1'b1; ld_addr = 32'h04; ld_data = 32'h1000_0011;
      tick();
      ld_addr = 32'h24; ld_data = 32'h9000_0099;
      tick();
      ld_en = 1'b0;
      req_valid = 1'b1; req_addr = 32'h04;
      tick();
      req_addr = 32'h24;
      tick();
      req_addr = 32'h08;
      tick();
      req_valid = 1'b0;
      chk("b2b #1 vld3", 32'(vld3), 32'd1);
      chk("b2b #1 dat3", dat3, 32'h1000_0011);
      tick();
      chk("b2b #2 dat3", dat3, 32'h9000_0099);
      tick();
      chk("b2b #3 vld3", 32'(vld3), 32'd1);
      chk("b2b #3 dat3", dat3, 32'h0000_0000);
      tick();
      chk("b2b drained vld3", 32'(vld3), 32'd0);

      // misaligned, out of range, dropped out-of-range load
      req_valid = 1'b1; req_addr = 32'h06;
      tick();
      req_valid = 1'b0;
      chk("misaligned err1", 32'(err1), 32'd1);
      chk("misaligned dat1", dat1, FILL);
      req_valid = 1'b1; req_addr = 32'h100;
      tick();
      req_valid = 1'b0;
      chk("oor err1", 32'(err1), 32'd2);
      ld_en = 1'b1; ld_addr = 32'h100; ld_data = 32'hFFFF_FFFF;
      tick();
      ld_en = 1'b0;
      req_valid = 1'b1; req_addr = 32'h0;
      tick();
      req_valid = 1'b0;
      chk("oor load ignored dat1", dat1, FILL);
      tick(); tick(); tick();

      // backpressure with three fetches in flight
      req_valid = 1'b1; req_addr = 32'h04;
      tick();
      req_addr = 32'h24;
      tick();
      req_addr = 32'h04;
      tick();
      rsp_ready = 1'b0; req_addr = 32'h24;
      #1;
      chk("stall rdy3", 32'(rdy3), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall hold vld3", 32'(vld3), 32'd1);
         chk("stall hold dat3", dat3, 32'h1000_0011);
      end
      rsp_ready = 1'b1; req_valid = 1'b0;
      tick();
      chk("drain #2 dat3", dat3, 32'h9000_0099);
      tick();
      chk("drain #3 dat3", dat3, 32'h1000_0011);
      tick();
      chk("drain done vld3", 32'(vld3), 32'd0);

      // same-edge fetch and load of an unloaded word is read-first
      req_valid = 1'b1; req_addr = 32'h10;
      ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'hA000_00AA;
      tick();
      ld_en = 1'b0;
      chk("read-first dat1", dat1, FILL);
      tick();
      req_valid = 1'b0;
      chk("after load dat1", dat1, 32'hA000_00AA);
      tick(); tick(); tick();

      // flush with two fetches in flight
      req_valid = 1'b1; req_addr = 32'h04;
      tick();
      req_addr = 32'h24;
      tick();
      flush = 1'b1; req_addr = 32'h04;
      #1;
      chk("flush rdy3", 32'(rdy3), 32'd0);
      chk("flush rdy1", 32'(rdy1), 32'd0);
      tick();
      flush = 1'b0; req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("post-flush vld3", 32'(vld3), 32'd0);
         tick();
      end

      // asynchronous reset mid-stream
      req_valid = 1'b1; req_addr = 32'h04;
      tick();
      req_addr = 32'h24;
      tick();
      req_addr = 32'h10;
      tick();
      chk("pre-reset vld3", 32'(vld3), 32'd1);
      rst = 1'b0; req_valid = 1'b0;
      #1;
      chk("async reset vld3", 32'(vld3), 32'd0);
      chk("async reset vld1", 32'(vld1), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      req_valid = 1'b1; req_addr = 32'h04;
      tick();
      chk("post-reset 0x04 dat1", dat1, FILL);
      req_addr = 32'h24;
      tick();
      chk("post-reset 0x24 dat1", dat1, FILL);
      req_addr = 32'h10;
      tick();
      req_valid = 1'b0;
      chk("post-reset 0x10 dat1", dat1, FILL);
      tick(); tick(); tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_mem_pipe.md
Name: instr_mem_pipe

Overview:
Parametrised, loadable instruction memory for the fetch stage, replacing the fixed 64-word combinational instruction store.
- Byte-addressed, word-granular.
- Fetch requests use a valid/ready handshake with configurable read latency and full-pipeline backpressure.
- A load port programs words at run time; a per-word valid bitmap makes never-loaded words return a fill instruction.
- Misaligned and out-of-range fetches are flagged rather than aliased.

Parameters:
DATA_W, 32, instruction word width in bits.
DEPTH, 64, number of words; power of two, at least 2.
ADDR_W, 32, byte-address width.
RD_LAT, 1, accept-to-response latency in cycles; legal 1..4.
FILL, 32'h00000000, word returned for unloaded or erroring fetches.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low (asserted at 0).
req_valid  in  1  fetch request present.
req_ready  out  1  block can accept a fetch this cycle.
req_addr  in  ADDR_W  fetch byte address.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer takes the response this cycle.
rsp_data  out  DATA_W  fetched instruction.
rsp_err  out  2  bit0 = misaligned (addr[1:0]!=0); bit1 = out of range (word index >= DEPTH).
ld_en  in  1  write strobe for the load port.
ld_addr  in  ADDR_W  load byte address; bits [1:0] ignored.
ld_data  in  DATA_W  load word.
flush  in  1  discard all in-flight fetches.

Behaviour:
- Word index = addr >> 2. In range iff every bit of addr[ADDR_W-1:2] above log2(DEPTH) is 0.
- Reset (rst=0, asynchronous):
  - All pipeline valid bits clear; rsp_valid=0, rsp_data=FILL, rsp_err=0.
  - All DEPTH word-valid bits clear.
  - Array contents are not cleared; the bitmap masks them.
  - Reset mid-operation discards every in-flight fetch; no response is ever produced for it.
- Stall = rsp_valid & ~rsp_ready.
- req_ready = ~stall & ~flush & rst.
- Accept = req_valid & req_ready.
- Pipeline: RD_LAT stages, each holding {valid, data, err}.
  - Stage 1 captures the array read on the accepting edge.
  - The final stage drives the rsp_* outputs.
  - While stall is high, every stage holds; no bubble compaction.
  - When not stalled, stages advance one per cycle; bubbles propagate.
- Latency: a response is visible exactly RD_LAT cycles after the accepting edge when rsp_ready is held high.
- Throughput: one fetch per cycle sustained. Responses return strictly in request order.
- Data rule, evaluated at accept:
  - If any rsp_err bit is set, data = FILL.
  - Else if the word-valid bit is 0, data = FILL and err = 0.
  - Else data = mem[index].
- rsp_data and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
- Load port:
  - On ld_en at the edge, an in-range ld_addr writes mem[index] and sets its valid bit.
  - An out-of-range load is silently dropped.
  - Loads are independent of stall and flush.
- Same-edge accept and load to the same word is read-first: the fetch returns the old data (FILL if previously unloaded). The next fetch sees the new word.
- Flush:
  - On the edge where flush=1, all stage valids clear, so rsp_valid=0 on the next cycle. This applies even while stalled.
  - No fetch is accepted in a flush cycle.
- rsp_valid may be high with rsp_ready low indefinitely; no timeout.
- RD_LAT outside 1..4 is a compile-time error (elaboration assertion).

Test Plan:
- Reset then fetch 0x0 with RD_LAT=1 -> rsp_valid one cycle later, data=FILL (0x00000000), err=0.
- Load 0x04=0x10000011 and 0x24=0x90000099, then back-to-back fetches 0x04, 0x24, 0x08 with RD_LAT=3 -> responses 0x10000011, 0x90000099, 0x00000000, on cycles +3, +4, +5, in order.
- Fetch 0x06 -> err=01, data=FILL. Fetch 0x100 (DEPTH=64) -> err=10, data=FILL. Load to 0x100 is ignored: a later fetch of 0x0 is unaffected.
- Hold rsp_ready=0 for 5 cycles with 3 fetches in flight (RD_LAT=3) -> req_ready=0 while rsp_valid=1; outputs stable. On release, all 3 drain in order with no loss or duplication.
- Same cycle: accept fetch 0x10 and load 0x10=0xA00000AA, both to a previously unloaded word -> response FILL; the next fetch of 0x10 returns 0xA00000AA.
- Assert flush with 2 fetches in flight -> no responses appear, req_ready=0 in the flush cycle. Separately, assert rst=0 mid-stream -> rsp_valid drops immediately (asynchronously), and after release every word reads FILL.
